// File: rtl/gerenciador_vidas.sv
// -----------------------------------------------------------------------------
// gerenciador_vidas
//   Life manager for the game datapath. It holds the player's life count,
//   takes hit (dano) and extra-life (bonus) events, opens an invulnerability
//   window after each accepted hit, and flags game over. It also emits
//   one-cycle event pulses for the control unit and the HUD.
//
// Parameters
//   N           width of the life count
//   VIDAS_INI   life count after clr   (1 <= VIDAS_INI <= VIDAS_MAX)
//   VIDAS_MAX   saturation ceiling      (VIDAS_MAX <= 2**N-1)
//   INV_CICLOS  enabled cycles of invulnerability after an accepted hit (>= 1)
//
// Ports
//   clock        in   system clock; all state changes on its rising edge
//   clr          in   synchronous active-high reset
//   ld           in   load D into the life count
//   D            in   load value (N bits)
//   en           in   game-running enable; 0 freezes all state and the timer
//   dano         in   hit event, level-sampled on each edge
//   bonus        in   extra-life event, level-sampled on each edge
//   vidas        out  current life count (registered)
//   invulneravel out  high during the post-hit window (registered)
//   game_over    out  high while in FIM (registered)
//   perdeu_vida  out  one-cycle pulse: a life was removed on this edge
//   ganhou_vida  out  one-cycle pulse: a life was added on this edge
//   dbg_estado   out  current FSM state, for debug and checkers
//
// Event interface: there is no valid/ready handshake. dano and bonus are plain
// levels. Each rising edge with en=1 (and no clr/ld) consumes whatever level is
// present. A held level is therefore seen again on the next enabled edge.
// -----------------------------------------------------------------------------
module gerenciador_vidas #(
  parameter int N          = 4,
  parameter int VIDAS_INI  = 3,
  parameter int VIDAS_MAX  = 5,
  parameter int INV_CICLOS = 4
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] D,
  input  logic         en,
  input  logic         dano,
  input  logic         bonus,
  output logic [N-1:0] vidas,
  output logic         invulneravel,
  output logic         game_over,
  output logic         perdeu_vida,
  output logic         ganhou_vida,
  output logic [1:0]   dbg_estado
);

  localparam int TW = $clog2(INV_CICLOS + 1);

  localparam logic [N-1:0]  VIDA_UM   = N'(1);
  localparam logic [N-1:0]  VIDA_INI  = N'(VIDAS_INI);
  localparam logic [N-1:0]  VIDA_MAX  = N'(VIDAS_MAX);
  localparam logic [TW-1:0] TIMER_INI = TW'(INV_CICLOS);
  localparam logic [TW-1:0] TIMER_UM  = TW'(1);

  typedef enum logic [1:0] {
    ATIVO = 2'd0,
    INVUL = 2'd1,
    FIM   = 2'd2
  } estado_t;

  estado_t       r_estado;
  logic [TW-1:0] r_timer;
  logic [N-1:0]  r_vidas;
  logic          r_invul;
  logic          r_game_over;
  logic          r_perdeu;
  logic          r_ganhou;

  logic          w_pode_ganhar;
  logic [N-1:0]  w_ld_valor;

  assign w_pode_ganhar = (r_vidas < VIDA_MAX);
  // Loads above the ceiling saturate instead of being rejected.
  assign w_ld_valor    = (D > VIDA_MAX) ? VIDA_MAX : D;

  always_ff @(posedge clock) begin
    if (clr) begin
      r_vidas     <= VIDA_INI;
      r_estado    <= ATIVO;
      r_timer     <= '0;
      r_invul     <= 1'b0;
      r_game_over <= 1'b0;
      r_perdeu    <= 1'b0;
      r_ganhou    <= 1'b0;
    end else if (ld) begin
      r_vidas  <= w_ld_valor;
      r_timer  <= '0;
      r_invul  <= 1'b0;
      r_perdeu <= 1'b0;
      r_ganhou <= 1'b0;
      if (w_ld_valor == '0) begin
        r_estado    <= FIM;
        r_game_over <= 1'b1;
      end else begin
        r_estado    <= ATIVO;
        r_game_over <= 1'b0;
      end
    end else if (en) begin
      r_perdeu <= 1'b0;
      r_ganhou <= 1'b0;
      case (r_estado)
        ATIVO: begin
          if (dano && bonus) begin
            // Hit and bonus cancel on the count, but the hit still opens the
            // window. The count is unchanged, so FIM cannot be reached here.
            r_estado <= INVUL;
            r_timer  <= TIMER_INI;
            r_invul  <= 1'b1;
          end else if (dano) begin
            r_vidas  <= r_vidas - VIDA_UM;
            r_perdeu <= 1'b1;
            if (r_vidas == VIDA_UM) begin
              r_estado    <= FIM;
              r_game_over <= 1'b1;
              r_invul     <= 1'b0;
            end else begin
              r_estado <= INVUL;
              r_timer  <= TIMER_INI;
              r_invul  <= 1'b1;
            end
          end else if (bonus && w_pode_ganhar) begin
            r_vidas  <= r_vidas + VIDA_UM;
            r_ganhou <= 1'b1;
          end
        end
        INVUL: begin
          // Hits are ignored during the window. Bonuses are still honoured.
          r_timer <= r_timer - TIMER_UM;
          if (r_timer == TIMER_UM) begin
            r_estado <= ATIVO;
            r_invul  <= 1'b0;
          end
          if (bonus && w_pode_ganhar) begin
            r_vidas  <= r_vidas + VIDA_UM;
            r_ganhou <= 1'b1;
          end
        end
        FIM: begin
          r_vidas <= '0;
        end
        default: begin
          // An unreachable encoding recovers into a safe, idle state.
          r_estado    <= ATIVO;
          r_timer     <= '0;
          r_invul     <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end else begin
      // Frozen: all state holds, and pulses never stretch across a stall.
      r_perdeu <= 1'b0;
      r_ganhou <= 1'b0;
    end
  end

  assign vidas        = r_vidas;
  assign invulneravel = r_invul;
  assign game_over    = r_game_over;
  assign perdeu_vida  = r_perdeu;
  assign ganhou_vida  = r_ganhou;
  assign dbg_estado   = r_estado;

endmodule

// File: tb/tb_gerenciador_vidas.sv
// -----------------------------------------------------------------------------
// tb_gerenciador_vidas
//   Directed bench for gerenciador_vidas (N=4, VIDAS_INI=3, VIDAS_MAX=5,
//   INV_CICLOS=4). Expected values are hand-computed constants. Outputs are
//   sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_gerenciador_vidas;

  localparam int N = 4;

  // ---------------------------------------------------------------- clock/reset
  logic         clock = 1'b0;
  logic         clr   = 1'b0;
  logic         ld    = 1'b0;
  logic [N-1:0] D     = '0;
  logic         en    = 1'b0;
  logic         dano  = 1'b0;
  logic         bonus = 1'b0;

  logic [N-1:0] vidas;
  logic         invulneravel;
  logic         game_over;
  logic         perdeu_vida;
  logic         ganhou_vida;
  logic [1:0]   dbg_estado;

  always #5 clock = ~clock;

  gerenciador_vidas #(
    .N(4), .VIDAS_INI(3), .VIDAS_MAX(5), .INV_CICLOS(4)
  ) dut (
    .clock(clock), .clr(clr), .ld(ld), .D(D), .en(en),
    .dano(dano), .bonus(bonus),
    .vidas(vidas), .invulneravel(invulneravel), .game_over(game_over),
    .perdeu_vida(perdeu_vida), .ganhou_vida(ganhou_vida),
    .dbg_estado(dbg_estado)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compares every output against one expected snapshot.
  task automatic check_all(input string tag, input logic [N-1:0] e_vidas,
                           input logic e_inv, input logic e_go,
                           input logic e_perdeu, input logic e_ganhou);
    check_eq({tag, ".vidas"},  vidas,        e_vidas);
    check_eq({tag, ".inv"},    invulneravel, e_inv);
    check_eq({tag, ".go"},     game_over,    e_go);
    check_eq({tag, ".perdeu"}, perdeu_vida,  e_perdeu);
    check_eq({tag, ".ganhou"}, ganhou_vida,  e_ganhou);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic do_ld(input logic [N-1:0] val);
    ld = 1'b1; D = val; step(); ld = 1'b0; D = '0;
  endtask

  // Runs the remaining window edges after a hit. After three of them
  // invulneravel must still be high, and the fourth one drops it.
  task automatic run_window(input string tag, input logic [N-1:0] e_vidas);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq({tag, ".win_inv"},   invulneravel, (i < 3) ? 1'b1 : 1'b0);
      check_eq({tag, ".win_vidas"}, vidas,        e_vidas);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    en = 1'b1;
    step();

    // 1. reset state
    do_clr();
    check_all("t1_reset", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. single hit, with dano held through the window
    dano = 1'b1; step();
    check_all("t2_hit", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    run_window("t2_held", 4'd2);
    dano = 1'b0;
    step();
    check_all("t2_after", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3. three spaced hits down to game over
    do_clr();
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t3_hit1", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    run_window("t3_w1", 4'd2);
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t3_hit2", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_window("t3_w2", 4'd1);
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t3_hit3", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    dano = 1'b1; bonus = 1'b1; step();
    check_all("t3_fim_both", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    dano = 1'b0; step();
    check_all("t3_fim_bonus", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    bonus = 1'b0;

    // 4. four consecutive bonuses from 3 saturate at 5
    do_clr();
    exp_q.push_back(4'd4); exp_q.push_back(4'd5);
    exp_q.push_back(4'd5); exp_q.push_back(4'd5);
    bonus = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t4_vidas",  vidas,       exp_q.pop_front());
      check_eq("t4_ganhou", ganhou_vida, (i < 2) ? 1'b1 : 1'b0);
    end
    bonus = 1'b0;
    check_eq("t4_q_empty", 8'(exp_q.size()), 8'd0);

    // 5. dano+bonus at vidas=1: no change, no FIM, window opens
    do_ld(4'd1);
    check_all("t5_ld1", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    dano = 1'b1; bonus = 1'b1; step(); dano = 1'b0; bonus = 1'b0;
    check_all("t5_both", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_window("t5_w", 4'd1);

    // 6. en=0 freezes the window mid-way
    do_clr();
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t6_hit", 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_all("t6_e1", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    dano = 1'b1; bonus = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("t6_frozen", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    dano = 1'b0; bonus = 1'b0;
    en = 1'b1;
    step();
    check_eq("t6_e2_inv", invulneravel, 1'b1);
    step();
    check_eq("t6_e3_inv", invulneravel, 1'b1);
    step();
    check_all("t6_e4", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // load above the ceiling saturates
    do_ld(4'd9);
    check_all("t6_ld9", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    // ld wins over a simultaneous hit
    dano = 1'b1; do_ld(4'd4); dano = 1'b0;
    check_all("t6_ld_vs_dano", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // clr in the middle of a window
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t6_hit2", 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    do_clr();
    check_all("t6_clr_mid", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("t6_after_clr_inv", invulneravel, 1'b0);

    // ld 0 enters FIM, and ld of a nonzero value leaves it
    do_ld(4'd0);
    check_all("t7_ld0", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_ld(4'd2);
    check_all("t7_ld2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // bonus during the window is honoured while the timer keeps running
    dano = 1'b1; step(); dano = 1'b0;
    check_all("t8_hit", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    bonus = 1'b1; step(); bonus = 1'b0;
    check_all("t8_bonus_inv", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); step();
    check_eq("t8_inv_e3", invulneravel, 1'b1);
    step();
    check_eq("t8_inv_e4", invulneravel, 1'b0);

    // ---------------------------------------------------------------- report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
